// File: rtl/hack_rom_loader_pkg.sv
// Shared types and constants for the Hack instruction ROM loader.
//   loader_state_e : loader FSM encoding
//   HACK_WORD_W    : Hack instruction word width
//   HACK_NOP       : default word served when no program is running
package hack_pkg;

  localparam int unsigned HACK_WORD_W = 16;
  localparam logic [HACK_WORD_W-1:0] HACK_NOP = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    RECV_HI,
    RECV_LO,
    RUN
  } loader_state_e;

endpackage

// File: rtl/hack_rom_loader_mem.sv
// Program ROM storage for the Hack loader: DEPTH x 16 words, one synchronous
// write port and one asynchronous read port. The array has no reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write word address
//   wdata : write word
//   raddr : read word address
//   rdata : word at raddr (combinational)
module hack_rom_mem
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [HACK_WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [HACK_WORD_W-1:0] rdata
);

  logic [HACK_WORD_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hack_rom_loader.sv
// Hack CPU instruction-side responder. Loads a big-endian byte stream
// (valid/ready) into the program ROM, holds the CPU in reset while loading,
// and serves instruction = ROM[pc] once the image is complete.
//   clk         : clock, all state on rising edge
//   reset       : asynchronous active-low reset
//   load_start  : one-cycle load request
//   load_len    : word count, sampled when load_start is accepted
//   rx_data     : program byte (high byte of each word first)
//   rx_valid    : rx_data valid
//   rx_ready    : loader accepts a byte this cycle
//   pc          : CPU program counter
//   instruction : ROM word at pc in RUN, FILL otherwise
//   cpu_reset   : registered active-high CPU reset
//   load_done   : high while running
//   load_err    : one-cycle pulse when load_start is rejected
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int unsigned            ADDR_W = 15,
  parameter logic [HACK_WORD_W-1:0] FILL   = HACK_NOP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic [15:0]            load_len,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  input  logic [15:0]            pc,
  output logic [HACK_WORD_W-1:0] instruction,
  output logic                   cpu_reset,
  output logic                   load_done,
  output logic                   load_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  loader_state_e state, stateNext;

  // One bit wider than the ROM address so a DEPTH-word load ends without wrap.
  logic [ADDR_W:0]        addr;
  logic [ADDR_W:0]        lastAddr;
  logic [7:0]             hiByte;
  logic                   lenOk;
  logic                   startAllowed;
  logic                   startAccept;
  logic                   startReject;
  logic                   rxFire;
  logic                   lastWord;
  logic                   memWe;
  logic [HACK_WORD_W-1:0] memRdata;

  assign lenOk        = (load_len != '0) && (32'(load_len) <= DEPTH);
  // Requests are only honoured between loads; mid-load they are ignored.
  assign startAllowed = (state == IDLE) || (state == RUN);
  assign startAccept  = load_start && startAllowed && lenOk;
  assign startReject  = load_start && startAllowed && !lenOk;
  assign rxFire       = rx_valid && rx_ready;
  assign lastWord     = (addr == lastAddr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (startAccept) stateNext = RECV_HI;
      RECV_HI: if (rxFire)      stateNext = RECV_LO;
      RECV_LO: if (rxFire)      stateNext = lastWord ? RUN : RECV_HI;
      RUN:     if (startAccept) stateNext = RECV_HI;
      default:                  stateNext = IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = (state == RECV_HI) || (state == RECV_LO);
    load_done = (state == RUN);
    memWe     = (state == RECV_LO) && rxFire;
    // Reads are only served in RUN, so they never collide with a write.
    if ((state == RUN) && (32'(pc) < DEPTH)) begin
      instruction = memRdata;
    end else begin
      instruction = FILL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_reset <= 1'b1;
      load_err  <= 1'b0;
      addr      <= '0;
      lastAddr  <= '0;
      hiByte    <= '0;
    end else begin
      // Registered from the next state so the CPU is released on the first
      // RUN cycle and re-held on the first cycle of a reload.
      cpu_reset <= (stateNext != RUN);
      load_err  <= startReject;
      if (startAccept) begin
        addr     <= '0;
        lastAddr <= (ADDR_W+1)'(load_len - 16'd1);
      end else if (memWe && !lastWord) begin
        addr <= addr + (ADDR_W+1)'(1);
      end
      if ((state == RECV_HI) && rxFire) begin
        hiByte <= rx_data;
      end
    end
  end

  hack_rom_mem #(
    .ADDR_W(ADDR_W)
  ) uRom (
    .clk   (clk),
    .we    (memWe),
    .waddr (addr[ADDR_W-1:0]),
    .wdata ({hiByte, rx_data}),
    .raddr (pc[ADDR_W-1:0]),
    .rdata (memRdata)
  );

endmodule

// File: tb/tb_hack_rom_loader.sv
module tb_hack_rom_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [15:0] load_len = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] pc = '0;
  logic [15:0] instruction;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int failures = 0;

  hack_rom_loader #(
    .ADDR_W(15),
    .FILL  (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_len    (load_len),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .pc          (pc),
    .instruction (instruction),
    .cpu_reset   (cpu_reset),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic        valid;
    logic [7:0]  data;
    logic [15:0] pc;
    logic        eCr;
    logic        eRr;
    logic        eLd;
    logic        eLe;
    logic [15:0] eIns;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [15:0] ln, input logic v,
                              input logic [7:0] d, input logic [15:0] p, input logic cr,
                              input logic rr, input logic ld, input logic le,
                              input logic [15:0] ins);
    vec_t r;
    r.start = st; r.len = ln; r.valid = v; r.data = d; r.pc = p;
    r.eCr = cr; r.eRr = rr; r.eLd = ld; r.eLe = le; r.eIns = ins;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkOut(input string tag, input logic cr, input logic rr, input logic ld,
                        input logic le, input logic [15:0] ins);
    chk({tag, " cpu_reset"}, 16'(cpu_reset), 16'(cr));
    chk({tag, " rx_ready"}, 16'(rx_ready), 16'(rr));
    chk({tag, " load_done"}, 16'(load_done), 16'(ld));
    chk({tag, " load_err"}, 16'(load_err), 16'(le));
    chk({tag, " instruction"}, instruction, ins);
  endtask

  // Presents one byte and holds it until the loader takes it (bounded wait).
  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!rx_ready) begin
      failures++;
      $display("FAIL sendByte timeout got=rx_ready0 expected=rx_ready1 byte=%h", b);
    end
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    //            st len      v  data   pc       cr rr ld le ins
    // normal load, rx_valid held high
    vecs.push_back(mk(1, 16'd3,    1, 8'h0A, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'h0A, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'hA1, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'hEF, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'hC8, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'hEA, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'h87, 16'h0000, 0, 0, 1, 0, 16'h0AA1));
    vecs.push_back(mk(0, 16'd0,    0, 8'h00, 16'h0001, 0, 0, 1, 0, 16'hEFC8));
    vecs.push_back(mk(0, 16'd0,    0, 8'h00, 16'h0002, 0, 0, 1, 0, 16'hEA87));
    vecs.push_back(mk(0, 16'd0,    0, 8'h00, 16'h8000, 0, 0, 1, 0, 16'h0000));
    // rejected requests while running
    vecs.push_back(mk(1, 16'd0,    0, 8'h00, 16'h0000, 0, 0, 1, 1, 16'h0AA1));
    vecs.push_back(mk(0, 16'd0,    0, 8'h00, 16'h0000, 0, 0, 1, 0, 16'h0AA1));
    vecs.push_back(mk(1, 16'h8001, 0, 8'h00, 16'h0000, 0, 0, 1, 1, 16'h0AA1));
    vecs.push_back(mk(0, 16'd0,    0, 8'h00, 16'h0000, 0, 0, 1, 0, 16'h0AA1));
    // reload of one word from RUN, with ignored mid-load requests
    vecs.push_back(mk(1, 16'd1,    0, 8'h00, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 16'd2,    1, 8'h00, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 16'd0,    1, 8'h05, 16'h0000, 0, 0, 1, 0, 16'h0005));
    vecs.push_back(mk(0, 16'd0,    0, 8'h00, 16'h0001, 0, 0, 1, 0, 16'hEFC8));
    // same image with gaps in rx_valid
    vecs.push_back(mk(1, 16'd3,    0, 8'h00, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'h0A, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    0, 8'h55, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'hA1, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    0, 8'h33, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 16'd0,    1, 8'hEF, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    0, 8'h66, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'hC8, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'hEA, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    0, 8'h99, 16'h0000, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 16'd0,    1, 8'h87, 16'h0000, 0, 0, 1, 0, 16'h0AA1));
    vecs.push_back(mk(0, 16'd0,    0, 8'h00, 16'h0001, 0, 0, 1, 0, 16'hEFC8));
    vecs.push_back(mk(0, 16'd0,    0, 8'h00, 16'h0002, 0, 0, 1, 0, 16'hEA87));

    // reset held low for two cycles
    repeat (2) @(posedge clk);
    #1;
    chkOut("reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    reset = 1'b1;
    step();
    chkOut("idle", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

    // zero-length request from IDLE
    load_start = 1'b1;
    load_len   = 16'd0;
    step();
    load_start = 1'b0;
    chkOut("idle len0", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    step();
    chkOut("idle len0 after", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    // oversize request from IDLE
    load_start = 1'b1;
    load_len   = 16'h8001;
    step();
    load_start = 1'b0;
    chkOut("idle lenMax+1", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      load_start = vecs[i].start;
      load_len   = vecs[i].len;
      rx_valid   = vecs[i].valid;
      rx_data    = vecs[i].data;
      pc         = vecs[i].pc;
      step();
      load_start = 1'b0;
      chkOut($sformatf("row%0d", i), vecs[i].eCr, vecs[i].eRr, vecs[i].eLd,
             vecs[i].eLe, vecs[i].eIns);
    end
    rx_valid = 1'b0;

    // reset in the middle of a load, after three bytes
    pc = 16'h0000;
    load_start = 1'b1;
    load_len   = 16'd2;
    step();
    load_start = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'h12; step();
    rx_data = 8'h34; step();
    rx_data = 8'h56; step();
    rx_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chkOut("midload reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    reset = 1'b1;
    step();
    chkOut("after midload reset", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

    // full-depth length is accepted
    load_start = 1'b1;
    load_len   = 16'h8000;
    step();
    load_start = 1'b0;
    chkOut("lenDepth accept", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    #1;
    chk("lenDepth abort rx_ready", 16'(rx_ready), 16'h0000);
    step();
    reset = 1'b1;
    step();

    // fresh full load after the aborted one
    load_start = 1'b1;
    load_len   = 16'd2;
    step();
    load_start = 1'b0;
    sendByte(8'hDE);
    sendByte(8'hAD);
    sendByte(8'hBE);
    sendByte(8'hEF);
    chkOut("reload run", 1'b0, 1'b0, 1'b1, 1'b0, 16'hDEAD);
    pc = 16'h0001; #1;
    chk("reload pc1", instruction, 16'hBEEF);
    pc = 16'h0002; #1;
    chk("reload pc2 old word", instruction, 16'hEA87);
    pc = 16'h8000; #1;
    chk("pc8000 fill", instruction, 16'h0000);
    pc = 16'hFFFF; #1;
    chk("pcFFFF fill", instruction, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
